// File: rtl/urf_pkg.sv
// -----------------------------------------------------------------------------
// urf_pkg
// Shared constants and types for the universal register array.
//   ADDR_WIDTH  : width of the read/write address ports (full-width compare)
//   urf_state_e : clear-sequencer state (CLEAR sweep, then IDLE)
// -----------------------------------------------------------------------------
package urf_pkg;

    localparam int ADDR_WIDTH = 32;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } urf_state_e;

endpackage

// File: rtl/urf_clear_seq.sv
// -----------------------------------------------------------------------------
// urf_clear_seq
// Post-reset clear sequencer. Walks a pointer across every entry of the array,
// asking for a zero write at each, then parks in IDLE until the next reset.
//   clk        : clock, rising edge
//   rst_ni     : synchronous active-low reset
//   clr_we_o   : request to write zero at clr_addr_o this edge
//   clr_addr_o : entry being cleared (zero-extended pointer)
//   busy_o     : registered, high from reset until the sweep completes
//   state_o    : current sequencer state (debug / gating)
// -----------------------------------------------------------------------------
module urf_clear_seq
    import urf_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_ni,
    output logic                  clr_we_o,
    output logic [ADDR_WIDTH-1:0] clr_addr_o,
    output logic                  busy_o,
    output urf_state_e            state_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    urf_state_e       state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             busy_q, busy_d;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        busy_d   = busy_q;
        clr_we_o = 1'b0;
        unique case (state_q)
            CLEAR: begin
                clr_we_o = 1'b1;
                if (ptr_q == PTR_W'(DEPTH - 1)) begin
                    // Last entry cleared on this edge: busy drops together
                    // with the move to IDLE, so it is low after DEPTH edges.
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + PTR_W'(1);
                end
            end
            IDLE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
        end
    end

    assign clr_addr_o = {{(ADDR_WIDTH - PTR_W){1'b0}}, ptr_q};
    assign busy_o     = busy_q;
    assign state_o    = state_q;

endmodule

// File: rtl/universal_reg_array.sv
// -----------------------------------------------------------------------------
// universal_reg_array
// DEPTH x DATA_WIDTH register file, one synchronous write port and one
// registered read port. After reset a hardware sweep zeroes every entry; while
// it runs (busy=1) all accesses are ignored and read_data stays 0.
//   clk        : clock, rising edge
//   rst        : synchronous active-low reset
//   read_addr  : read index, full 32-bit compare (>= DEPTH reads as 0)
//   write_addr : write index, full 32-bit compare (>= DEPTH write dropped)
//   write_data : write data
//   write_en   : write strobe
//   read_en    : read strobe; read_data holds when low
//   read_data  : registered read result (read-before-write on collision)
//   busy       : registered, high during reset and the clear sweep
// -----------------------------------------------------------------------------
module universal_reg_array
    import urf_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  write_en,
    input  logic                  read_en,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  busy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] read_data_q;

    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;
    urf_state_e            seq_state;

    logic                  idle;
    logic                  wr_hit;
    logic                  rd_hit;

    urf_clear_seq #(
        .DEPTH (DEPTH)
    ) u_clear_seq (
        .clk        (clk),
        .rst_ni     (rst),
        .clr_we_o   (clr_we),
        .clr_addr_o (clr_addr),
        .busy_o     (busy),
        .state_o    (seq_state)
    );

    assign idle   = (seq_state == IDLE);
    assign wr_hit = write_addr < ADDR_WIDTH'(DEPTH);
    assign rd_hit = read_addr  < ADDR_WIDTH'(DEPTH);

    // Storage has no reset so it can map onto RAM; the sweep provides the
    // zero initialisation instead. Nothing is written while rst is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (clr_we) begin
                mem[clr_addr[PTR_W-1:0]] <= '0;
            end else if (idle && write_en && wr_hit) begin
                mem[write_addr[PTR_W-1:0]] <= write_data;
            end
        end
    end

    // Reads sample the array before this edge's write lands, giving
    // read-before-write on a same-address collision.
    always_ff @(posedge clk) begin
        if (!rst) begin
            read_data_q <= '0;
        end else if (idle && read_en) begin
            read_data_q <= rd_hit ? mem[read_addr[PTR_W-1:0]] : '0;
        end
    end

    assign read_data = read_data_q;

endmodule

// File: tb/tb_universal_reg_array.sv
module tb_universal_reg_array;

  localparam int DW    = 8;
  localparam int DEPTH = 32;

  logic          clk;
  logic          rst;
  logic [31:0]   read_addr;
  logic [31:0]   write_addr;
  logic [DW-1:0] write_data;
  logic          write_en;
  logic          read_en;
  logic [DW-1:0] read_data;
  logic          busy;

  int tests = 0;
  int fails = 0;

  // Behavioural reference: plain array plus a countdown of entries still to clear.
  logic [DW-1:0] m_mem [DEPTH];
  logic [DW-1:0] m_rd;
  logic          m_busy;
  int            m_left;

  typedef struct {
    logic          we;
    logic [31:0]   wa;
    logic [DW-1:0] wd;
    logic          re;
    logic [31:0]   ra;
    logic [DW-1:0] exp_rd;
  } vec_t;

  vec_t vecs [$];

  universal_reg_array #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .read_addr  (read_addr),
    .write_addr (write_addr),
    .write_data (write_data),
    .write_en   (write_en),
    .read_en    (read_en),
    .read_data  (read_data),
    .busy       (busy)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Advance the model with the inputs currently driven, then clock the DUT.
  task automatic cycle();
    if (!rst) begin
      m_rd   = '0;
      m_left = DEPTH;
      m_busy = 1'b1;
    end else if (m_left > 0) begin
      m_mem[DEPTH - m_left] = '0;
      m_left--;
      m_busy = (m_left != 0);
    end else begin
      if (read_en) m_rd = (read_addr < DEPTH) ? m_mem[int'(read_addr)] : '0;
      if (write_en && write_addr < DEPTH) m_mem[int'(write_addr)] = write_data;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [31:0] wa, input logic [DW-1:0] wd,
                       input logic re, input logic [31:0] ra);
    write_en   = we;
    write_addr = wa;
    write_data = wd;
    read_en    = re;
    read_addr  = ra;
  endtask

  task automatic idle_inputs();
    drive(1'b0, 32'd0, '0, 1'b0, 32'd0);
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    cycle();
    rst = 1'b1;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 100) begin
      cycle();
      n++;
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL %s: busy still 0x%0h after %0d cycles, expected 0x0", name, busy, n);
    end
  endtask

  task automatic write_word(input logic [31:0] a, input logic [DW-1:0] d);
    drive(1'b1, a, d, 1'b0, 32'd0);
    cycle();
    idle_inputs();
  endtask

  task automatic read_word(input logic [31:0] a, output logic [DW-1:0] d);
    drive(1'b0, 32'd0, '0, 1'b1, a);
    cycle();
    d = read_data;
    idle_inputs();
  endtask

  // ---------------- test ----------------
  initial begin
    logic [DW-1:0] rd;
    int            n;

    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_rd   = '0;
    m_busy = 1'b1;
    m_left = DEPTH;
    rst    = 1'b0;
    idle_inputs();

    // Reset then wait: busy high for exactly DEPTH edges after release.
    cycle();
    check("reset_busy", busy, 1);
    check("reset_rd", read_data, 0);
    rst = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      cycle();
      check($sformatf("sweep_busy_%0d", i), busy, (i < DEPTH) ? 1 : 0);
      check($sformatf("sweep_rd_%0d", i), read_data, 0);
    end

    // Table-driven IDLE vectors; each expected value is the register after the edge.
    vecs.push_back('{1'b1, 32'd0,          8'hA5, 1'b1, 32'd0,          8'h00});
    vecs.push_back('{1'b0, 32'd0,          8'h00, 1'b1, 32'd0,          8'hA5});
    vecs.push_back('{1'b1, 32'd31,         8'h3C, 1'b1, 32'd0,          8'hA5});
    vecs.push_back('{1'b0, 32'd0,          8'h00, 1'b1, 32'd31,         8'h3C});
    vecs.push_back('{1'b1, 32'd32,         8'h11, 1'b1, 32'd32,         8'h00});
    vecs.push_back('{1'b1, 32'hFFFF_FFFF,  8'h11, 1'b1, 32'hFFFF_FFFF,  8'h00});
    vecs.push_back('{1'b0, 32'd0,          8'h00, 1'b1, 32'd0,          8'hA5});
    vecs.push_back('{1'b0, 32'd0,          8'h00, 1'b1, 32'd31,         8'h3C});
    vecs.push_back('{1'b1, 32'd7,          8'h10, 1'b1, 32'd7,          8'h00});
    vecs.push_back('{1'b1, 32'd7,          8'h20, 1'b1, 32'd7,          8'h10});
    vecs.push_back('{1'b0, 32'd0,          8'h00, 1'b1, 32'd7,          8'h20});
    vecs.push_back('{1'b0, 32'd0,          8'h00, 1'b0, 32'd0,          8'h20});
    vecs.push_back('{1'b1, 32'd3,          8'h55, 1'b1, 32'd31,         8'h3C});
    vecs.push_back('{1'b0, 32'd0,          8'h00, 1'b1, 32'd3,          8'h55});
    vecs.push_back('{1'b1, 32'h0000_0100,  8'h99, 1'b1, 32'h0000_0100,  8'h00});
    vecs.push_back('{1'b0, 32'd0,          8'h00, 1'b1, 32'd0,          8'hA5});
    foreach (vecs[i]) begin
      drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].re, vecs[i].ra);
      cycle();
      check($sformatf("vec%0d_rd", i), read_data, vecs[i].exp_rd);
      check($sformatf("vec%0d_busy", i), busy, 0);
    end
    idle_inputs();

    // Clear verification: fill with 0xFF, reset, every entry reads 0.
    for (int a = 0; a < DEPTH; a++) write_word(a, 8'hFF);
    read_word(32'd17, rd);
    check("fill_ff", rd, 8'hFF);
    pulse_reset();
    // Accesses during the sweep must be ignored and read_data stays 0.
    drive(1'b1, 32'd5, 8'h77, 1'b1, 32'd5);
    for (int i = 0; i < 4; i++) begin
      cycle();
      check($sformatf("busy_access_rd_%0d", i), read_data, 0);
    end
    idle_inputs();
    wait_idle("clear_wait");
    n = 0;
    for (int a = 0; a < DEPTH; a++) begin
      read_word(a, rd);
      if (rd !== 8'h00) n++;
    end
    check("clear_all_nonzero_count", n, 0);
    read_word(32'd5, rd);
    check("busy_write_dropped", rd, 8'h00);

    // Reset mid-sweep: sweep restarts and takes a full DEPTH edges.
    write_word(32'd9, 8'h42);
    pulse_reset();
    for (int i = 0; i < 10; i++) cycle();
    check("mid_busy_before", busy, 1);
    pulse_reset();
    check("mid_rd_reset", read_data, 0);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      cycle();
      n++;
    end
    check("mid_sweep_len", n, DEPTH);
    read_word(32'd9, rd);
    check("mid_cleared", rd, 8'h00);

    // Randomized traffic against the reference model, with rare resets.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] wa, ra;
      wa = ($urandom_range(0, 9) == 0) ? $urandom() : $urandom_range(0, DEPTH - 1);
      ra = ($urandom_range(0, 9) == 0) ? $urandom() : $urandom_range(0, DEPTH - 1);
      rst = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
      drive($urandom_range(0, 1), wa, $urandom_range(0, 255), $urandom_range(0, 1), ra);
      cycle();
      check($sformatf("rand%0d_rd", i), read_data, m_rd);
      check($sformatf("rand%0d_busy", i), busy, m_busy);
    end
    rst = 1'b1;
    idle_inputs();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/universal_reg_array.md
Name: universal_reg_array

Overview:
- Parameterised single-port-write / single-port-read register file, DEPTH entries of DATA_WIDTH bits, used as a generic storage block in the URF project.
- Synchronous write and registered read.
- A hardware clear sequencer zeroes every entry after reset; `busy` flags the sequence, and all accesses are ignored while it runs.

Parameters:
- DATA_WIDTH, 8, width of each entry and of write_data/read_data.
- DEPTH, 32, number of entries; any value >= 2, need not be a power of two.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  reset, synchronous, active-low; entire block held in reset while rst=0.
- read_addr  input  32  entry index to read; full 32-bit compare, not truncated.
- write_addr  input  32  entry index to write; full 32-bit compare.
- write_data  input  DATA_WIDTH  data to write.
- write_en  input  1  write strobe, sampled on the rising edge.
- read_en  input  1  read strobe, sampled on the rising edge.
- read_data  output  DATA_WIDTH  registered read result.
- busy  output  1  high while reset is asserted or the clear sweep runs.

Behaviour:
- Reset (rst=0 at a rising edge):
  - read_data<=0, busy<=1, clear pointer<=0, state<=CLEAR.
  - Storage array is not directly reset, so it can infer RAM.
- State machine, two states:
  - CLEAR: each edge with rst=1 writes 0 to mem[ptr] and increments ptr. The edge that clears entry DEPTH-1 moves to IDLE and sets busy<=0. busy therefore reads 0 after exactly DEPTH rising edges with rst=1.
  - IDLE: normal operation; stays in IDLE until the next reset.
- During CLEAR, write_en and read_en are ignored and read_data holds 0.
- Reset mid-sweep restarts the sweep from entry 0.
- Write (IDLE, write_en=1, write_addr<DEPTH): mem[write_addr]<=write_data at the edge. If write_addr>=DEPTH the write is dropped silently.
- Read (IDLE, read_en=1):
  - read_data<=mem[read_addr] at the edge, visible one cycle after the strobe.
  - If read_addr>=DEPTH, read_data<=0.
- read_en=0: read_data holds its previous value.
- Simultaneous read and write to the same address on the same edge: read-before-write; read_data returns the old contents, new data is visible from the next read.
- Read and write to different addresses on the same edge: both are performed.
- busy is registered, with no combinational path from inputs.

Decomposition:
- Package urf_pkg:
  - ADDR_WIDTH=32 constant.
  - State typedef enum logic {CLEAR, IDLE}.
- Optional sub-module urf_clear_seq: owns the pointer, state and busy, and exports clr_we/clr_addr to the array. Everything else stays in universal_reg_array.

Test Plan:
- Reset then wait: drive rst=0 for 1 edge, then rst=1 → busy=1 for 32 edges, busy=0 after the 32nd; read_data=0 throughout.
- Write/read back in IDLE: write 0xA5 to addr 0, then read_en addr 0 → read_data=0xA5 one cycle later. Repeat for addr 31 with 0x3C.
- Clear verification: fill all 32 entries with 0xFF, pulse reset, wait for busy=0, read every address → all 0x00.
- Access during busy: write_en=1 with addr 5 data 0x77 issued during CLEAR, then read addr 5 after busy=0 → 0x00.
- Out of range: write 0x11 to addr 32 and addr 0xFFFF_FFFF, then read them → read_data=0; entries 0 and 31 are unchanged.
- Same-address collision: mem[7]=0x10, then write 0x20 and read addr 7 on the same edge → read_data=0x10; the next read → 0x20.
- Reset mid-sweep: assert reset 10 edges into CLEAR → busy remains 1 for a full 32 edges after release.
